// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample serializer: default word width and FSM encoding.
package i2s_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2sState_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// Registers bck/lrck in the sck domain and derives the bck-fall and slot-boundary strobes.
module i2s_edge_detect (
  input  logic sck,
  input  logic reset,
  input  logic bck,
  input  logic lrck,
  output logic fall,
  output logic leftBound,
  output logic rightBound
);

  logic bckQ;
  logic lrckQ;

  assign fall       = bckQ & ~bck;
  assign leftBound  = fall &  lrckQ & ~lrck;
  assign rightBound = fall & ~lrckQ &  lrck;

  // lrck is only trusted at bck falls, where the oscillator changes it
  always_ff @(posedge sck) begin
    if (reset) begin
      bckQ  <= 1'b0;
      lrckQ <= 1'b0;
    end else begin
      bckQ <= bck;
      if (fall) lrckQ <= lrck;
    end
  end

endmodule

// File: rtl/i2s_sample_serializer.sv
// I2S transmitter: one-frame holding register feeding an MSB-first shift register,
// with underrun detection at every left-slot boundary.
module i2s_sample_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    sck,
  input  logic                    reset,
  input  logic                    bck,
  input  logic                    lrck,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    data,
  output logic                    underrun_pulse,
  output logic [CNT_WIDTH-1:0]    underrun_count
);

  i2sState_t state, stateNext;

  logic fall, leftBound, rightBound;
  logic loadRight;
  logic accept, full, fullNext;
  logic [SAMPLE_WIDTH-1:0] shiftReg, rightReg, holdL, holdR;

  i2s_edge_detect uEdge (
    .sck       (sck),
    .reset     (reset),
    .bck       (bck),
    .lrck      (lrck),
    .fall      (fall),
    .leftBound (leftBound),
    .rightBound(rightBound)
  );

  always_ff @(posedge sck) begin
    if (reset) state <= SYNC;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadRight = 1'b0;
    unique case (state)
      SYNC:  if (leftBound) stateNext = LEFT;
      LEFT: begin
        if (rightBound) begin
          stateNext = RIGHT;
          loadRight = 1'b1;
        end
      end
      RIGHT: if (leftBound) stateNext = LEFT;
      default: stateNext = SYNC;
    endcase
  end

  // A frame accepted on the boundary cycle lands in the holding register
  // after the boundary has already sampled full=0, so it serves the next frame.
  assign accept   = sample_valid & sample_ready;
  assign fullNext = (full & ~leftBound) | accept;

  always_ff @(posedge sck) begin
    if (reset) begin
      data           <= 1'b0;
      sample_ready   <= 1'b0;
      full           <= 1'b0;
      holdL          <= '0;
      holdR          <= '0;
      shiftReg       <= '0;
      rightReg       <= '0;
      underrun_pulse <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun_pulse <= 1'b0;
      full           <= fullNext;
      sample_ready   <= ~fullNext;

      if (accept) begin
        holdL <= sample_left;
        holdR <= sample_right;
      end

      // Every fall, boundary or not, emits the pending MSB (one-bck delay)
      if (fall) data <= (state == SYNC) ? 1'b0 : shiftReg[SAMPLE_WIDTH-1];

      if (leftBound) begin
        if (full) begin
          shiftReg <= holdL;
          rightReg <= holdR;
        end else begin
          shiftReg       <= '0;
          rightReg       <= '0;
          underrun_pulse <= 1'b1;
          if (underrun_count != {CNT_WIDTH{1'b1}}) underrun_count <= underrun_count + 1'b1;
        end
      end else if (loadRight) begin
        shiftReg <= rightReg;
      end else if (fall) begin
        shiftReg <= {shiftReg[SAMPLE_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
